// File: rtl/issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : issue_stage
// Description : In-order dual-issue stage with register scoreboard and EX
//               pipeline register. Optional macro ISSUE_WB_BYPASS_EN lets
//               same-cycle writebacks release hazards (0-cycle wb-to-issue).
// Revision    : 1.0 - initial release
// ============================================================================
module issue_stage #(
    parameter int PAYLOAD_W  = 256,
    parameter int DUAL_ISSUE = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 ex_stall,
    input  logic                 uop_valid0,
    input  logic                 uop_valid1,
    input  logic [4:0]           rd0,
    input  logic [4:0]           rj0,
    input  logic [4:0]           rk0,
    input  logic [4:0]           rd1,
    input  logic [4:0]           rj1,
    input  logic [4:0]           rk1,
    input  logic                 wr_rd0,
    input  logic                 wr_rd1,
    input  logic                 use_rj0,
    input  logic                 use_rk0,
    input  logic                 use_rj1,
    input  logic                 use_rk1,
    input  logic                 is_mem0,
    input  logic                 is_mem1,
    input  logic                 has_exc0,
    input  logic                 has_exc1,
    input  logic [PAYLOAD_W-1:0] payload0,
    input  logic [PAYLOAD_W-1:0] payload1,
    output logic [1:0]           read_en,
    output logic                 ex_valid0,
    output logic                 ex_valid1,
    output logic [PAYLOAD_W-1:0] ex_payload0,
    output logic [PAYLOAD_W-1:0] ex_payload1,
    output logic [4:0]           ex_rd0,
    output logic [4:0]           ex_rd1,
    input  logic                 wb_en0,
    input  logic                 wb_en1,
    input  logic [4:0]           wb_addr0,
    input  logic [4:0]           wb_addr1
);

    localparam logic        c_dual_en   = (DUAL_ISSUE != 0);
    localparam logic [31:0] c_r0_mask   = 32'hFFFF_FFFE;

    logic [31:0] r_busy;
    logic [31:0] w_clr;
    logic [31:0] w_set;
    logic [31:0] w_busy_chk;
    logic        w_haz0;
    logic        w_haz1;
    logic        w_pair;
    logic        w_can0;
    logic        w_can1;
    logic        w_set0;
    logic        w_set1;

    // Both ports naming the same register collapse into one bit.
    always_comb begin
        w_clr = '0;
        if (wb_en0) w_clr[wb_addr0] = 1'b1;
        if (wb_en1) w_clr[wb_addr1] = 1'b1;
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign w_busy_chk = r_busy & ~w_clr;
`else
    assign w_busy_chk = r_busy;
`endif

    // busy[0] is held at zero, so r0 operands never raise a hazard.
    assign w_haz0 = (use_rj0 & w_busy_chk[rj0]) | (use_rk0 & w_busy_chk[rk0]) |
                    (wr_rd0 & w_busy_chk[rd0]);
    assign w_haz1 = (use_rj1 & w_busy_chk[rj1]) | (use_rk1 & w_busy_chk[rk1]) |
                    (wr_rd1 & w_busy_chk[rd1]);

    assign w_pair = wr_rd0 & (rd0 != 5'd0) &
                    ((use_rj1 & (rj1 == rd0)) | (use_rk1 & (rk1 == rd0)) |
                     (wr_rd1 & (rd1 == rd0)));

    assign w_can0 = uop_valid0 & ~flush & ~ex_stall & (has_exc0 | ~w_haz0);
    assign w_can1 = w_can0 & c_dual_en & uop_valid1 & ~has_exc0 & ~has_exc1 &
                    ~w_haz1 & ~w_pair & ~(is_mem0 & is_mem1);

    assign read_en = {w_can1, w_can0};

    assign w_set0 = w_can0 & wr_rd0 & ~has_exc0 & (rd0 != 5'd0);
    assign w_set1 = w_can1 & wr_rd1 & ~has_exc1 & (rd1 != 5'd0);

    always_comb begin
        w_set = '0;
        if (w_set0) w_set[rd0] = 1'b1;
        if (w_set1) w_set[rd1] = 1'b1;
    end

    // Sets are applied after clears so a new writer keeps the register busy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
        end else if (flush) begin
            r_busy <= '0;
        end else begin
            r_busy <= ((r_busy & ~w_clr) | w_set) & c_r0_mask;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_valid0   <= 1'b0;
            ex_valid1   <= 1'b0;
            ex_payload0 <= '0;
            ex_payload1 <= '0;
            ex_rd0      <= 5'd0;
            ex_rd1      <= 5'd0;
        end else if (flush) begin
            ex_valid0   <= 1'b0;
            ex_valid1   <= 1'b0;
        end else if (!ex_stall) begin
            ex_valid0   <= w_can0;
            ex_valid1   <= w_can1;
            ex_payload0 <= payload0;
            ex_payload1 <= payload1;
            ex_rd0      <= (wr_rd0 && !has_exc0) ? rd0 : 5'd0;
            ex_rd1      <= (wr_rd1 && !has_exc1) ? rd1 : 5'd0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_issue_stage
// Description : Directed plus randomized bench for issue_stage against a
//               scoreboard reference model. Honours ISSUE_WB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_issue_stage;

    localparam int PW = 256;
`ifdef ISSUE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rstn;
    logic          flush, ex_stall;
    logic          uop_valid0, uop_valid1;
    logic [4:0]    rd0, rj0, rk0, rd1, rj1, rk1;
    logic          wr_rd0, wr_rd1, use_rj0, use_rk0, use_rj1, use_rk1;
    logic          is_mem0, is_mem1, has_exc0, has_exc1;
    logic [PW-1:0] payload0, payload1;
    logic [1:0]    read_en;
    logic          ex_valid0, ex_valid1;
    logic [PW-1:0] ex_payload0, ex_payload1;
    logic [4:0]    ex_rd0, ex_rd1;
    logic          wb_en0, wb_en1;
    logic [4:0]    wb_addr0, wb_addr1;

    always #5 clk = ~clk;

    issue_stage #(.PAYLOAD_W(PW), .DUAL_ISSUE(1)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .ex_stall(ex_stall),
        .uop_valid0(uop_valid0), .uop_valid1(uop_valid1),
        .rd0(rd0), .rj0(rj0), .rk0(rk0), .rd1(rd1), .rj1(rj1), .rk1(rk1),
        .wr_rd0(wr_rd0), .wr_rd1(wr_rd1),
        .use_rj0(use_rj0), .use_rk0(use_rk0), .use_rj1(use_rj1), .use_rk1(use_rk1),
        .is_mem0(is_mem0), .is_mem1(is_mem1), .has_exc0(has_exc0), .has_exc1(has_exc1),
        .payload0(payload0), .payload1(payload1), .read_en(read_en),
        .ex_valid0(ex_valid0), .ex_valid1(ex_valid1),
        .ex_payload0(ex_payload0), .ex_payload1(ex_payload1),
        .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
        .wb_en0(wb_en0), .wb_en1(wb_en1), .wb_addr0(wb_addr0), .wb_addr1(wb_addr1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: which architectural registers await a writeback,
    // and what the EX register should hold.
    bit            mbusy [32];
    bit            ev0, ev1;
    logic [4:0]    erd0, erd1;
    logic [PW-1:0] epl0, epl1;

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit wb_hits(input logic [4:0] r);
        return (wb_en0 && wb_addr0 == r) || (wb_en1 && wb_addr1 == r);
    endfunction

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (BYP && wb_hits(r)) return 1'b0;
        return mbusy[r];
    endfunction

    function automatic bit blocked(input bit urj, input bit urk, input bit wr,
                                   input logic [4:0] rj, input logic [4:0] rk,
                                   input logic [4:0] rd);
        return (urj && pending(rj)) || (urk && pending(rk)) || (wr && pending(rd));
    endfunction

    function automatic logic [1:0] model_read_en();
        bit a, b, dep;
        a = uop_valid0 && !flush && !ex_stall &&
            (has_exc0 || !blocked(use_rj0, use_rk0, wr_rd0, rj0, rk0, rd0));
        dep = wr_rd0 && rd0 != 5'd0 &&
              ((use_rj1 && rj1 == rd0) || (use_rk1 && rk1 == rd0) || (wr_rd1 && rd1 == rd0));
        b = a && uop_valid1 && !has_exc0 && !has_exc1 && !dep && !(is_mem0 && is_mem1) &&
            !blocked(use_rj1, use_rk1, wr_rd1, rj1, rk1, rd1);
        return {b, a};
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = mbusy[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        ev0 = 1'b0; ev1 = 1'b0;
    endtask

    task automatic idle();
        flush = 0; ex_stall = 0; uop_valid0 = 0; uop_valid1 = 0;
        rd0 = 0; rj0 = 0; rk0 = 0; rd1 = 0; rj1 = 0; rk1 = 0;
        wr_rd0 = 0; wr_rd1 = 0; use_rj0 = 0; use_rk0 = 0; use_rj1 = 0; use_rk1 = 0;
        is_mem0 = 0; is_mem1 = 0; has_exc0 = 0; has_exc1 = 0;
        payload0 = '0; payload1 = '0;
        wb_en0 = 0; wb_en1 = 0; wb_addr0 = 0; wb_addr1 = 0;
    endtask

    task automatic set0(input logic [4:0] d, input logic [4:0] j, input logic [4:0] k,
                        input bit wr, input bit uj, input bit uk, input bit mem);
        uop_valid0 = 1; rd0 = d; rj0 = j; rk0 = k; wr_rd0 = wr; use_rj0 = uj; use_rk0 = uk;
        is_mem0 = mem; has_exc0 = 0; payload0 = {8{$urandom}};
    endtask

    task automatic set1(input logic [4:0] d, input logic [4:0] j, input logic [4:0] k,
                        input bit wr, input bit uj, input bit uk, input bit mem);
        uop_valid1 = 1; rd1 = d; rj1 = j; rk1 = k; wr_rd1 = wr; use_rj1 = uj; use_rk1 = uk;
        is_mem1 = mem; has_exc1 = 0; payload1 = {8{$urandom}};
    endtask

    // One clock: check the pop request, advance the model across the edge,
    // then check the EX register and scoreboard. Entered and left at negedge.
    task automatic cycle();
        logic [1:0] e;
        #1;
        e = model_read_en();
        chk("read_en", PW'(read_en), PW'(e));
        @(posedge clk);
        if (flush) begin
            model_reset();
        end else begin
            if (wb_en0) mbusy[wb_addr0] = 1'b0;
            if (wb_en1) mbusy[wb_addr1] = 1'b0;
            if (!ex_stall) begin
                ev0 = e[0]; ev1 = e[1];
                epl0 = payload0; epl1 = payload1;
                erd0 = (wr_rd0 && !has_exc0) ? rd0 : 5'd0;
                erd1 = (wr_rd1 && !has_exc1) ? rd1 : 5'd0;
                if (e[0] && wr_rd0 && !has_exc0 && rd0 != 5'd0) mbusy[rd0] = 1'b1;
                if (e[1] && wr_rd1 && !has_exc1 && rd1 != 5'd0) mbusy[rd1] = 1'b1;
            end
        end
        #1;
        chk("ex_valid0", PW'(ex_valid0), PW'(ev0));
        chk("ex_valid1", PW'(ex_valid1), PW'(ev1));
        if (ev0) begin
            chk("ex_rd0", PW'(ex_rd0), PW'(erd0));
            chk("ex_payload0", ex_payload0, epl0);
        end
        if (ev1) begin
            chk("ex_rd1", PW'(ex_rd1), PW'(erd1));
            chk("ex_payload1", ex_payload1, epl1);
        end
        chk("busy", PW'(dut.r_busy), PW'(busy_vec()));
        @(negedge clk);
    endtask

    initial begin
        idle();
        model_reset();
        rstn = 0;
        repeat (3) @(negedge clk);
        chk("rst_ex_valid0", PW'(ex_valid0), '0);
        chk("rst_ex_valid1", PW'(ex_valid1), '0);
        chk("rst_ex_payload0", ex_payload0, '0);
        chk("rst_ex_payload1", ex_payload1, '0);
        chk("rst_ex_rd", PW'({ex_rd0, ex_rd1}), '0);
        chk("rst_busy", PW'(dut.r_busy), '0);
        chk("rst_read_en", PW'(read_en), '0);
        rstn = 1;
        @(negedge clk);

        // Independent pair: add r1,r2,r3 / add r4,r5,r6
        set0(1, 2, 3, 1, 1, 1, 0); set1(4, 5, 6, 1, 1, 1, 0);
        #1 chk("pair_read_en", PW'(read_en), PW'(2'b11));
        cycle();
        chk("pair_ex_rd0", PW'(ex_rd0), PW'(5'd1));
        chk("pair_ex_rd1", PW'(ex_rd1), PW'(5'd4));
        chk("pair_busy", PW'(dut.r_busy & 32'h12), PW'(32'h12));
        idle(); wb_en0 = 1; wb_addr0 = 1; wb_en1 = 1; wb_addr1 = 4;
        cycle();

        // Pair RAW on r5, then wait for its writeback
        idle(); set0(5, 0, 0, 1, 0, 0, 0); set1(8, 5, 0, 1, 1, 0, 0);
        #1 chk("raw_read_en", PW'(read_en), PW'(2'b01));
        cycle();
        idle(); set0(8, 5, 0, 1, 1, 0, 0);
        cycle();
        cycle();
        wb_en0 = 1; wb_addr0 = 5;
        #1 chk("raw_wb_read_en", PW'(read_en), PW'({1'b0, BYP}));
        cycle();
        wb_en0 = 0;
        cycle();

        // Two loads: one per cycle
        idle(); set0(10, 0, 0, 1, 0, 0, 1); set1(11, 0, 0, 1, 0, 0, 1);
        cycle();
        set0(11, 0, 0, 1, 0, 0, 1); set1(12, 0, 0, 1, 0, 0, 1);
        #1 chk("mem_read_en", PW'(read_en), PW'(2'b01));
        cycle();

        // Stall with writeback of r7 still clearing the scoreboard
        idle(); set0(7, 0, 0, 1, 0, 0, 0);
        cycle();
        idle(); ex_stall = 1; set0(13, 1, 2, 1, 1, 1, 0); set1(14, 2, 3, 1, 1, 1, 0);
        wb_en1 = 1; wb_addr1 = 7;
        cycle();
        chk("stall_busy7", PW'(dut.r_busy[7]), '0);

        // Flush with r3 pending and EX slot 0 occupied
        idle(); set0(3, 0, 0, 1, 0, 0, 0);
        cycle();
        flush = 1; set0(15, 0, 0, 1, 0, 0, 0); set1(16, 0, 0, 1, 0, 0, 0);
        #1 chk("flush_read_en", PW'(read_en), '0);
        cycle();

        // Issue writer of r9 while r9 is written back: stays busy
        idle(); set0(9, 0, 0, 1, 0, 0, 0); wb_en0 = 1; wb_addr0 = 9;
        cycle();
        chk("setwins_busy9", PW'(dut.r_busy[9]), PW'(1'b1));

        // Asynchronous reset mid-stream
        idle();
        #2 rstn = 0;
        #1;
        chk("async_ex_valid0", PW'(ex_valid0), '0);
        chk("async_ex_valid1", PW'(ex_valid1), '0);
        chk("async_busy", PW'(dut.r_busy), '0);
        model_reset();
        #1 rstn = 1;
        @(negedge clk);

        // Randomized traffic over a small register window
        for (int n = 0; n < 400; n++) begin
            uop_valid0 = ($urandom_range(0, 9) < 8);
            uop_valid1 = ($urandom_range(0, 9) < 7);
            rd0 = 5'($urandom_range(0, 7)); rj0 = 5'($urandom_range(0, 7)); rk0 = 5'($urandom_range(0, 7));
            rd1 = 5'($urandom_range(0, 7)); rj1 = 5'($urandom_range(0, 7)); rk1 = 5'($urandom_range(0, 7));
            wr_rd0 = ($urandom_range(0, 9) < 7); wr_rd1 = ($urandom_range(0, 9) < 7);
            use_rj0 = ($urandom_range(0, 9) < 6); use_rk0 = ($urandom_range(0, 9) < 6);
            use_rj1 = ($urandom_range(0, 9) < 6); use_rk1 = ($urandom_range(0, 9) < 6);
            is_mem0 = ($urandom_range(0, 3) == 0); is_mem1 = ($urandom_range(0, 3) == 0);
            has_exc0 = ($urandom_range(0, 9) == 0); has_exc1 = ($urandom_range(0, 9) == 0);
            payload0 = {8{$urandom}}; payload1 = {8{$urandom}};
            ex_stall = ($urandom_range(0, 99) < 15);
            flush = ($urandom_range(0, 99) < 3);
            wb_en0 = ($urandom_range(0, 9) < 4); wb_addr0 = 5'($urandom_range(0, 7));
            wb_en1 = ($urandom_range(0, 9) < 4); wb_addr1 = 5'($urandom_range(0, 7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- In-order dual-issue stage directly downstream of the decode stage.
- Inspects the two decoded uops at the head of the fetch buffer and checks them against a register scoreboard and pair-hazard rules.
- Returns the read_en pop request to decode in the same cycle.
- Registers the issued uops into the EX pipeline register and tracks pending register writes until writeback.

Parameters:
PAYLOAD_W, 256, width of the opaque per-uop payload (uop, imm, pc, pc_next, exception, badv, unknown) carried to EX
DUAL_ISSUE, 1, 1 = up to two uops per cycle; 0 = at most uop0 per cycle

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush from commit
ex_stall  in  1  EX cannot accept new uops this cycle
uop_valid0, uop_valid1  in  1 each  decoder slot holds a real uop (fetch buffer not empty at that slot)
rd0, rj0, rk0, rd1, rj1, rk1  in  5 each  register fields from decode
wr_rd0, wr_rd1  in  1 each  uop writes rd
use_rj0, use_rk0, use_rj1, use_rk1  in  1 each  uop reads rj / rk
is_mem0, is_mem1  in  1 each  uop uses the single LSU pipe
has_exc0, has_exc1  in  1 each  uop carries a nonzero exception code
payload0, payload1  in  PAYLOAD_W each  opaque uop bundle
read_en  out  2  pop request to decode: 00 none, 01 one, 11 two; 10 never driven
ex_valid0, ex_valid1  out  1 each  EX register slot valid
ex_payload0, ex_payload1  out  PAYLOAD_W each  registered payloads
ex_rd0, ex_rd1  out  5 each  registered destination; 0 when the uop does not write
wb_en0, wb_en1  in  1 each  writeback ports
wb_addr0, wb_addr1  in  5 each  writeback register numbers

Behaviour:
- Reset (rstn low, asynchronous): ex_valid0/1=0, ex_payload0/1=0, ex_rd0/1=0, all scoreboard busy bits=0. read_en is combinational; it reads 00 while flush or ex_stall is high.
- Scoreboard: busy[31:1]. r0 is never busy, never a hazard, and never marked.
- can0 requires all of: uop_valid0, ~flush, ~ex_stall, and either has_exc0 or no hazard on uop0.
  - A hazard is any of: use_rj0 with busy[rj0]; use_rk0 with busy[rk0]; wr_rd0 with busy[rd0].
- can1 requires all of:
  - can0, DUAL_ISSUE=1, uop_valid1, ~has_exc0, ~has_exc1.
  - No scoreboard hazard on uop1 (same test as uop0).
  - No pair hazard: when wr_rd0 and rd0!=0, uop1 does not read rd0 and does not write rd0 (WAW).
  - Not both is_mem0 and is_mem1.
- read_en = {can1, can0}. Issue is strictly in order; uop1 never issues alone.
- On a clock edge with ~ex_stall and ~flush:
  - ex_valid0<=can0 and ex_valid1<=can1.
  - Payloads and rd capture the inputs.
  - ex_rdN<=(wr_rdN && ~has_excN) ? rdN : 0.
- ex_stall high: EX registers hold and no scoreboard set occurs. Writeback clears still apply.
- Scoreboard set: on issue of a writing, non-excepting uop with rd!=0, set busy[rd].
- Scoreboard clear: wb_enN clears busy[wb_addrN].
- Set and clear of the same register in one cycle: set wins (new writer).
- Both wb ports naming the same register: single clear.
- Hazard check uses busy before this cycle's clears; writeback-to-issue latency is 1 cycle.
- flush (synchronous, priority over everything): ex_valid0/1<=0, all busy<=0, read_en=00 in that cycle.
- Latency: a uop presented while eligible appears on ex_valid the next cycle.

Optional Feature:
ISSUE_WB_BYPASS_EN
- Defined: hazard checks use busy after this cycle's wb clears, so a consumer issues in the same cycle its producer writes back. Writeback-to-issue latency is 0.
- Undefined: behaviour as above, 1-cycle latency.

Test Plan:
- Independent pair add r1,r2,r3 / add r4,r5,r6, scoreboard clear -> read_en=11; next cycle ex_valid0=ex_valid1=1, ex_rd0=1, ex_rd1=4, busy[1]=busy[4]=1.
- Pair RAW: uop0 writes r5, uop1 reads r5 -> read_en=01. Next cycle uop1 is now slot 0 and busy[5]=1, so read_en=00 until wb_en0=1, wb_addr0=5. It then issues 1 cycle after wb, or the same cycle with ISSUE_WB_BYPASS_EN.
- Two loads (is_mem0=is_mem1=1), no register hazards -> read_en=01 each cycle, one load per cycle.
- ex_stall=1 with two valid uops -> read_en=00, ex_* unchanged. wb_en1 clearing r7 during the stall still clears busy[7].
- flush=1 with busy[3]=1 and ex_valid0=1 -> next cycle ex_valid0/1=0, all busy=0, and read_en was 00 in the flush cycle.
- Issue writer of r9 while wb_en0=1, wb_addr0=9 in the same cycle -> busy[9] stays 1. Async rstn pulse mid-stream -> ex_valid0/1 and busy drop to 0 immediately, without waiting for a clock edge.
